// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared types and opcode decode helpers for the HI/LO multiply controller.
package muldiv_pkg;

   // Multiply-class opcodes presented by the EX stage; codes 9..15 are unused
   typedef enum logic [3:0] {
      MD_NOP   = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_MADD  = 4'd3,
      MD_MADDU = 4'd4,
      MD_MSUB  = 4'd5,
      MD_MSUBU = 4'd6,
      MD_MTHI  = 4'd7,
      MD_MTLO  = 4'd8
   } md_op_t;

   // Controller states: idle, waiting on the multiplier, accumulate writeback
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_ACC  = 2'd2
   } md_state_t;

   // True for every op that needs the multiplier
   function automatic logic is_mul(input md_op_t op);
      case (op)
         MD_MULT, MD_MULTU, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: is_mul = 1'b1;
         default:                                                is_mul = 1'b0;
      endcase
   endfunction

   // True for ops whose product is two's-complement signed
   function automatic logic is_signed(input md_op_t op);
      case (op)
         MD_MULT, MD_MADD, MD_MSUB: is_signed = 1'b1;
         default:                  is_signed = 1'b0;
      endcase
   endfunction

   // True for ops that fold the product into the existing HI/LO
   function automatic logic is_acc(input md_op_t op);
      case (op)
         MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: is_acc = 1'b1;
         default:                              is_acc = 1'b0;
      endcase
   endfunction

   // True for accumulate ops that subtract the product
   function automatic logic is_sub(input md_op_t op);
      case (op)
         MD_MSUB, MD_MSUBU: is_sub = 1'b1;
         default:           is_sub = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// Bundle of the EX-stage request, multiplier handshake and HI/LO result signals.
interface hilo_muldiv_ctrl_if #(parameter int W = 32);
   import muldiv_pkg::*;

   logic         op_valid;
   md_op_t       op;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         flush;
   logic         busy;
   logic         mul_in_valid;
   logic         mul_sign;
   logic [W-1:0] mul_a;
   logic [W-1:0] mul_b;
   logic         mul_out_valid;
   logic [W-1:0] mul_hi;
   logic [W-1:0] mul_lo;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   // Pipeline and multiplier side: drives requests and products, observes results
   modport master (
      output op_valid, op, op_a, op_b, flush, mul_out_valid, mul_hi, mul_lo,
      input  busy, mul_in_valid, mul_sign, mul_a, mul_b, hi, lo
   );

   // Controller side
   modport slave (
      input  op_valid, op, op_a, op_b, flush, mul_out_valid, mul_hi, mul_lo,
      output busy, mul_in_valid, mul_sign, mul_a, mul_b, hi, lo
   );

endinterface

// File: rtl/hilo_muldiv_ctrl_acc.sv
// Combinational 2W-bit add/subtract of {hi,lo} with the latched product, wrapping modulo 2^2W.
module hilo_acc #(
   parameter int W = 32
) (
   input  logic [W-1:0] hi,
   input  logic [W-1:0] lo,
   input  logic [W-1:0] prod_hi,
   input  logic [W-1:0] prod_lo,
   input  logic         sub,
   output logic [W-1:0] res_hi,
   output logic [W-1:0] res_lo
);

   logic [2*W-1:0] acc;
   logic [2*W-1:0] prod;
   logic [2*W-1:0] res;

   assign acc  = {hi, lo};
   assign prod = {prod_hi, prod_lo};

   // Signedness only matters for the product, so the accumulate is a plain wrap-around add/sub
   always_comb begin
      res = sub ? (acc - prod) : (acc + prod);
   end

   assign res_hi = res[2*W-1:W];
   assign res_lo = res[W-1:0];

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// Sequences multiply-class ops on the shared multiplier and owns the architectural HI/LO registers.
module hilo_muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int W = 32
) (
   input logic               clk,
   input logic               rst,
   hilo_muldiv_ctrl_if.slave bus
);

   md_state_t    state;
   md_state_t    state_n;
   md_op_t       op_reg;
   logic [W-1:0] a_reg;
   logic [W-1:0] b_reg;
   logic         sign_reg;
   logic [W-1:0] prod_hi_reg;
   logic [W-1:0] prod_lo_reg;
   logic [W-1:0] hi_reg;
   logic [W-1:0] lo_reg;
   logic [W-1:0] acc_hi;
   logic [W-1:0] acc_lo;

   logic latch_ops;
   logic latch_prod;
   logic wr_hi;
   logic wr_lo;
   logic wr_prod;
   logic wr_acc;
   logic busy_c;
   logic in_valid_c;

   hilo_acc #(.W(W)) u_acc (
      .hi      (hi_reg),
      .lo      (lo_reg),
      .prod_hi (prod_hi_reg),
      .prod_lo (prod_lo_reg),
      .sub     (is_sub(op_reg)),
      .res_hi  (acc_hi),
      .res_lo  (acc_lo)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_n;
   end

   // Next state, stall request and write strobes; flush suppresses every write and drops busy
   always_comb begin
      state_n    = state;
      busy_c     = 1'b0;
      in_valid_c = 1'b0;
      latch_ops  = 1'b0;
      latch_prod = 1'b0;
      wr_hi      = 1'b0;
      wr_lo      = 1'b0;
      wr_prod    = 1'b0;
      wr_acc     = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (bus.op_valid && !bus.flush) begin
               if (is_mul(bus.op)) begin
                  busy_c    = 1'b1;
                  latch_ops = 1'b1;
                  state_n   = ST_MUL;
               end else if (bus.op == MD_MTHI) begin
                  wr_hi = 1'b1;
               end else if (bus.op == MD_MTLO) begin
                  wr_lo = 1'b1;
               end
            end
         end
         ST_MUL: begin
            in_valid_c = 1'b1;
            if (bus.flush) begin
               state_n = ST_IDLE;
            end else if (bus.mul_out_valid) begin
               if (is_acc(op_reg)) begin
                  latch_prod = 1'b1;
                  busy_c     = 1'b1;
                  state_n    = ST_ACC;
               end else begin
                  wr_prod = 1'b1;
                  state_n = ST_IDLE;
               end
            end else begin
               busy_c = 1'b1;
            end
         end
         ST_ACC: begin
            wr_acc  = !bus.flush;
            state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Operand and product capture; operands stay frozen for the whole multiply
   always_ff @(posedge clk) begin
      if (rst) begin
         op_reg      <= MD_NOP;
         a_reg       <= '0;
         b_reg       <= '0;
         sign_reg    <= 1'b0;
         prod_hi_reg <= '0;
         prod_lo_reg <= '0;
      end else begin
         if (latch_ops) begin
            op_reg   <= bus.op;
            a_reg    <= bus.op_a;
            b_reg    <= bus.op_b;
            sign_reg <= is_signed(bus.op);
         end
         if (latch_prod) begin
            prod_hi_reg <= bus.mul_hi;
            prod_lo_reg <= bus.mul_lo;
         end
      end
   end

   // Architectural HI/LO update from moves, plain products or the accumulator
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_reg <= '0;
         lo_reg <= '0;
      end else if (wr_prod) begin
         hi_reg <= bus.mul_hi;
         lo_reg <= bus.mul_lo;
      end else if (wr_acc) begin
         hi_reg <= acc_hi;
         lo_reg <= acc_lo;
      end else begin
         if (wr_hi) hi_reg <= bus.op_a;
         if (wr_lo) lo_reg <= bus.op_a;
      end
   end

   assign bus.busy         = busy_c;
   assign bus.mul_in_valid = in_valid_c;
   assign bus.mul_sign     = sign_reg;
   assign bus.mul_a        = (state == ST_IDLE) ? bus.op_a : a_reg;
   assign bus.mul_b        = (state == ST_IDLE) ? bus.op_b : b_reg;
   assign bus.hi           = hi_reg;
   assign bus.lo           = lo_reg;

endmodule
